bullet_scheduler: RTL and testbench
===================================

Name: bullet_scheduler

Overview:
- Arbitrates fire requests from the player ship and the enemy ship onto a shared pool of NUM_SLOTS bullet slots.
- Picks a free slot, loads it with X position and direction, and pulses that slot's start line.
- Confirms the slot went in use, then applies a per-requester cooldown.
- Sits between the input/AI logic and the bullet slot instances; all timing is in 60 Hz frames.

Parameters:
- NUM_SLOTS, 4, number of bullet slot instances managed.
- PLAYER_COOLDOWN, 12, frames after a confirmed player launch before the player may fire again.
- ENEMY_COOLDOWN, 30, frames after a confirmed enemy launch before the enemy may fire again.
- CD_W, 6, cooldown counter width; must hold max(PLAYER_COOLDOWN, ENEMY_COOLDOWN).

Ports:
- clk_60hz  in  1  frame clock.
- reset  in  1  asynchronous, active-high.
- fire_player  in  1  level request from the player fire button.
- fire_enemy  in  1  level request from the enemy AI.
- player_x  in  10  player ship X.
- enemy_x  in  10  enemy ship X.
- slot_in_use  in  NUM_SLOTS  in-use flags returned by the slots.
- start_bullet  out  NUM_SLOTS  one-hot start pulse to the slots.
- bullet_x  out  10  X value loaded into the started slot.
- bullet_dir  out  1  direction: 1 = up (player), 0 = down (enemy).
- active_count  out  3  population count of slot_in_use (combinational).
- launch_fault  out  1  sticky error flag.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk_60hz. On reset:
  - start_bullet=0, bullet_x=0, bullet_dir=0, launch_fault=0.
  - Both cooldowns=0, state=IDLE, last_grant=enemy, so the player wins the first tie.
- Reset asserted mid-launch aborts immediately; no start pulse survives reset.
- Request valid: req_p = fire_player && cd_p==0; req_e = fire_enemy && cd_e==0.
- Cooldown counters decrement by 1 each frame while nonzero, saturating at 0.
- Free slot: lowest index i with slot_in_use[i]==0. "None free" when all bits are 1.
- State IDLE:
  - Condition: (req_p||req_e) and a free slot exists.
  - Grant on a single request goes to that requester; on a tie it goes to the requester other than last_grant (round-robin).
  - Registers idx, start_bullet = one-hot(idx), bullet_x and bullet_dir for the winner; updates last_grant; next state LAUNCH.
  - With requests but no free slot: no grant, requests are held (not dropped), stay IDLE.
- State LAUNCH: start_bullet is high for exactly this one frame. Next edge: start_bullet=0, bullet_x and bullet_dir hold, next state CONFIRM.
- State CONFIRM: sample slot_in_use[idx].
  - If 1: load the winner's cooldown (PLAYER_COOLDOWN or ENEMY_COOLDOWN), go to IDLE.
  - If 0: set launch_fault=1 (sticky until reset), load no cooldown, go to IDLE.
- Latency: request valid before edge k -> start_bullet high after edge k -> slot in use after edge k+1 -> cooldown loaded at edge k+2.
  - Earliest next grant is edge k+3, so at most one launch per 3 frames overall.
- Loaded cooldown value N means the requester is blocked for N full frames after the confirm edge.
- Requests and fire-line changes arriving during LAUNCH/CONFIRM are ignored; only IDLE arbitrates.
- A slot that frees during CONFIRM is visible at the next IDLE evaluation.
- Widths: bullet_x is a straight copy of the 10-bit X input; no arithmetic. Cooldown counters never wrap below 0.

Decomposition:
- Shared package game_pkg:
  - State encoding IDLE/LAUNCH/CONFIRM.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Requester IDs REQ_PLAYER/REQ_ENEMY.
  - Default cooldown constants.
- One natural sub-module: free_slot_finder (combinational priority encoder plus popcount over slot_in_use, outputs idx, any_free, count).

Test Plan:
- Reset, then fire_player=1, player_x=320, all slots free.
  - Required: start_bullet=0001 for one frame, bullet_x=320, bullet_dir=1.
  - Bench model sets in_use[0]; cd_p=12 at the confirm edge; next player grant no earlier than 12 frames later.
- fire_player and fire_enemy held together from reset, slots free.
  - Required grants alternate player (slot0), enemy (slot1) while cooldowns permit.
  - Enemy launch has bullet_dir=0 and bullet_x=enemy_x.
- slot_in_use=1111, fire_player=1.
  - Required: no start pulse.
  - Release slot2 -> start_bullet=0100 within one frame of IDLE evaluation.
- Bench model ignores start (slot_in_use stays 0).
  - Required: launch_fault=1 at the CONFIRM edge, no cooldown loaded, re-grant allowed at the next IDLE.
- Assert reset during LAUNCH.
  - Required: start_bullet drops to 0 asynchronously; all outputs at reset values.
  - active_count tracks slot_in_use (e.g. 1011 -> 3).

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the bullet scheduling logic: FSM states, direction
// and requester encodings, and default timing constants (in 60 Hz frames).
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        CONFIRM = 2'd2
    } sched_state_e;

    typedef enum logic {
        REQ_PLAYER = 1'b0,
        REQ_ENEMY  = 1'b1
    } req_id_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_NUM_SLOTS       = 4;
    localparam int DEF_PLAYER_COOLDOWN = 12;
    localparam int DEF_ENEMY_COOLDOWN  = 30;
    localparam int DEF_CD_W            = 6;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational search over the slot in-use flags: lowest free index,
// whether any slot is free, and how many slots are busy.
module free_slot_finder #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2,
    parameter int COUNT_W   = 3
) (
    input  logic [NUM_SLOTS-1:0] slot_in_use,
    output logic [IDX_W-1:0]     idx,
    output logic                 any_free,
    output logic [COUNT_W-1:0]   count
);

    // Priority encode from the top down so the lowest free index wins last.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_in_use[i]) begin
                idx      = IDX_W'(i);
                any_free = 1'b1;
            end else begin
                any_free = any_free;
            end
        end
    end

    // Population count of busy slots.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count = count + COUNT_W'(slot_in_use[i]);
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Arbitrates player/enemy fire requests onto a pool of bullet slots, launches
// the chosen slot, confirms it went busy and applies per-requester cooldowns.
module bullet_scheduler
    import game_pkg::*;
#(
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int PLAYER_COOLDOWN = DEF_PLAYER_COOLDOWN,
    parameter int ENEMY_COOLDOWN  = DEF_ENEMY_COOLDOWN,
    parameter int CD_W            = DEF_CD_W
) (
    input  logic                 clk_60hz,
    input  logic                 reset,
    input  logic                 fire_player,
    input  logic                 fire_enemy,
    input  logic [9:0]           player_x,
    input  logic [9:0]           enemy_x,
    input  logic [NUM_SLOTS-1:0] slot_in_use,
    output logic [NUM_SLOTS-1:0] start_bullet,
    output logic [9:0]           bullet_x,
    output logic                 bullet_dir,
    output logic [2:0]           active_count,
    output logic                 launch_fault
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [CD_W-1:0] P_CD = CD_W'(PLAYER_COOLDOWN);
    localparam logic [CD_W-1:0] E_CD = CD_W'(ENEMY_COOLDOWN);
    localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = NUM_SLOTS'(1);

    sched_state_e         state_q, state_d;
    req_id_e              last_q, last_d, win_s;
    logic [IDX_W-1:0]     idx_q, idx_d, free_idx_s;
    logic [NUM_SLOTS-1:0] start_q, start_d;
    logic [9:0]           bx_q, bx_d;
    logic                 dir_q, dir_d;
    logic                 fault_q, fault_d;
    logic [CD_W-1:0]      cd_p_q, cd_p_d, cd_e_q, cd_e_d;
    logic                 any_free_s, req_p_s, req_e_s;

    free_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W),
        .COUNT_W   (3)
    ) u_finder (
        .slot_in_use (slot_in_use),
        .idx         (free_idx_s),
        .any_free    (any_free_s),
        .count       (active_count)
    );

    assign req_p_s = fire_player && (cd_p_q == '0);
    assign req_e_s = fire_enemy  && (cd_e_q == '0);

    // Round-robin on a tie: the side that did not win last time goes next.
    assign win_s = req_p_s ? (req_e_s ? ((last_q == REQ_ENEMY) ? REQ_PLAYER : REQ_ENEMY)
                                      : REQ_PLAYER)
                           : REQ_ENEMY;

    // Next-state logic: arbitration in IDLE, one-frame start pulse, confirm.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        start_d = '0;
        bx_d    = bx_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        cd_p_d  = (cd_p_q != '0) ? (cd_p_q - CD_W'(1)) : '0;
        cd_e_d  = (cd_e_q != '0) ? (cd_e_q - CD_W'(1)) : '0;
        case (state_q)
            IDLE: begin
                // Without a free slot requests stay pending; they are level inputs.
                if ((req_p_s || req_e_s) && any_free_s) begin
                    idx_d   = free_idx_s;
                    start_d = ONE_HOT0 << free_idx_s;
                    bx_d    = (win_s == REQ_PLAYER) ? player_x : enemy_x;
                    dir_d   = (win_s == REQ_PLAYER) ? DIR_UP : DIR_DOWN;
                    last_d  = win_s;
                    state_d = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                state_d = CONFIRM;
            end
            CONFIRM: begin
                if (slot_in_use[idx_q]) begin
                    if (last_q == REQ_PLAYER) begin
                        cd_p_d = P_CD;
                    end else begin
                        cd_e_d = E_CD;
                    end
                end else begin
                    fault_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any launch in flight.
    always_ff @(posedge clk_60hz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= REQ_ENEMY;
            idx_q   <= '0;
            start_q <= '0;
            bx_q    <= 10'd0;
            dir_q   <= 1'b0;
            fault_q <= 1'b0;
            cd_p_q  <= '0;
            cd_e_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            bx_q    <= bx_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
            cd_p_q  <= cd_p_d;
            cd_e_q  <= cd_e_d;
        end
    end

    assign start_bullet = start_q;
    assign bullet_x     = bx_q;
    assign bullet_dir   = dir_q;
    assign launch_fault = fault_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed self-checking bench for bullet_scheduler with a simple slot model
// that marks a slot busy one frame after its start pulse.
module tb_bullet_scheduler;

    logic       clk_60hz = 1'b0;
    logic       reset = 1'b1;
    logic       fire_player = 1'b0;
    logic       fire_enemy = 1'b0;
    logic [9:0] player_x = 10'd0;
    logic [9:0] enemy_x = 10'd0;
    logic [3:0] slots = 4'd0;
    logic [3:0] pend = 4'd0;
    logic       model_en = 1'b1;
    logic [3:0] start_bullet;
    logic [9:0] bullet_x;
    logic       bullet_dir;
    logic [2:0] active_count;
    logic       launch_fault;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         waited;

    bullet_scheduler dut (
        .clk_60hz     (clk_60hz),
        .reset        (reset),
        .fire_player  (fire_player),
        .fire_enemy   (fire_enemy),
        .player_x     (player_x),
        .enemy_x      (enemy_x),
        .slot_in_use  (slots),
        .start_bullet (start_bullet),
        .bullet_x     (bullet_x),
        .bullet_dir   (bullet_dir),
        .active_count (active_count),
        .launch_fault (launch_fault)
    );

    always #5 clk_60hz = ~clk_60hz;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: sample 1 time unit after the edge; the slot model goes busy
    // one frame after it saw the start pulse.
    task automatic tick();
        @(posedge clk_60hz);
        #1;
        if (model_en) slots = slots | pend;
        pend = start_bullet;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fire_player = 1'b0;
        fire_enemy = 1'b0;
        model_en = 1'b1;
        slots = 4'd0;
        pend = 4'd0;
        repeat (2) @(posedge clk_60hz);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_start();
        waited = 0;
        do begin
            tick();
            waited++;
        end while (start_bullet == 4'd0 && waited < 40);
    endtask

    initial begin
        // Reset state
        #1;
        chk_val("rst_start", start_bullet, 4'd0);
        chk_val("rst_x", bullet_x, 10'd0);
        chk_val("rst_dir", bullet_dir, 1'b0);
        chk_val("rst_fault", launch_fault, 1'b0);
        chk_val("rst_count", active_count, 3'd0);

        // Single player launch and cooldown
        do_reset();
        player_x = 10'd320;
        fire_player = 1'b1;
        tick();
        chk_val("p1_start", start_bullet, 4'b0001);
        chk_val("p1_x", bullet_x, 10'd320);
        chk_val("p1_dir", bullet_dir, 1'b1);
        tick();
        chk_val("p1_start_drop", start_bullet, 4'd0);
        chk_val("p1_x_hold", bullet_x, 10'd320);
        tick();
        chk_val("p1_count", active_count, 3'd1);
        chk_val("p1_nofault", launch_fault, 1'b0);
        wait_start();
        chk_val("p1_cd_wait", waited, 13);
        chk_val("p1_start2", start_bullet, 4'b0010);

        // Simultaneous requests alternate
        do_reset();
        player_x = 10'd100;
        enemy_x = 10'd700;
        fire_player = 1'b1;
        fire_enemy = 1'b1;
        tick();
        chk_val("tie_p_start", start_bullet, 4'b0001);
        chk_val("tie_p_dir", bullet_dir, 1'b1);
        chk_val("tie_p_x", bullet_x, 10'd100);
        tick();
        tick();
        tick();
        chk_val("tie_e_start", start_bullet, 4'b0010);
        chk_val("tie_e_dir", bullet_dir, 1'b0);
        chk_val("tie_e_x", bullet_x, 10'd700);
        tick();
        tick();
        wait_start();
        chk_val("tie_p2_wait", waited, 10);
        chk_val("tie_p2_start", start_bullet, 4'b0100);
        chk_val("tie_p2_dir", bullet_dir, 1'b1);

        // No free slot holds the request
        do_reset();
        slots = 4'b1111;
        player_x = 10'd42;
        fire_player = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("full_nostart", start_bullet, 4'd0);
        end
        chk_val("full_count", active_count, 3'd4);
        slots = 4'b1011;
        #1;
        chk_val("count_1011", active_count, 3'd3);
        tick();
        chk_val("free2_start", start_bullet, 4'b0100);
        chk_val("free2_x", bullet_x, 10'd42);

        // Slot never goes busy -> fault, no cooldown
        do_reset();
        model_en = 1'b0;
        player_x = 10'd5;
        fire_player = 1'b1;
        tick();
        chk_val("flt_start", start_bullet, 4'b0001);
        tick();
        chk_val("flt_pre", launch_fault, 1'b0);
        tick();
        chk_val("flt_set", launch_fault, 1'b1);
        tick();
        chk_val("flt_regrant", start_bullet, 4'b0001);
        chk_val("flt_sticky", launch_fault, 1'b1);

        // Async reset during LAUNCH
        #2;
        reset = 1'b1;
        #1;
        chk_val("arst_start", start_bullet, 4'd0);
        chk_val("arst_x", bullet_x, 10'd0);
        chk_val("arst_dir", bullet_dir, 1'b0);
        chk_val("arst_fault", launch_fault, 1'b0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
